// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : FIFO-buffered UART transmitter, 8N1/8N2 frames, back-to-back.
//           Optional parity bit when UART_TX_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [15:0]          baud_div_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_bit_w = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;

  assign w_full     = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = tx_valid_i && !w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign tx_ready_o = !w_full;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data_i;
  end

  // ---------------------------------------------------------------- FSM
  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [15:0]          r_div;
  logic [15:0]          w_div_nxt;
  logic [15:0]          r_timer;
  logic [15:0]          w_timer_nxt;
  logic [c_bit_w-1:0]   r_bit_idx;
  logic [c_bit_w-1:0]   w_bit_nxt;
  logic                 r_stop_idx;
  logic                 w_stop_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_bit_end;
  logic                 w_load;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
  logic                 w_par_nxt;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_div      <= '0;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_div      <= w_div_nxt;
      r_timer    <= w_timer_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_stop_idx <= w_stop_nxt;
      r_tx       <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit_idx;
    w_stop_nxt  = r_stop_idx;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    w_bit_end   = (r_timer == r_div);
    w_timer_nxt = w_bit_end ? '0 : r_timer + 16'd1;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (!w_empty) w_load = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == c_bit_w'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
            w_stop_nxt  = 1'b0;
          end else begin
            w_bit_nxt = r_bit_idx + c_bit_w'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when data is waiting
            if (!w_empty) w_load = 1'b1;
            else          w_state_nxt = S_IDLE;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Divisor is sampled only here, so mid-frame changes wait for the next frame
    if (w_load) begin
      w_pop       = 1'b1;
      w_state_nxt = S_START;
      w_shift_nxt = w_head;
      w_div_nxt   = baud_div_i;
      w_timer_nxt = '0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = (^w_head) ^ 1'(PARITY_ODD);
`endif
    end

    // Line value is registered from the next state, so tx_o never glitches
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign tx_o   = r_tx;
  assign busy_o = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire
